// File: rtl/matrix_op_scheduler.sv
// matrix_op_scheduler: serial packed 2x2 element-wise add/sub reusing one adder; in(in_valid/in_ready, op_sub, A, B) -> out(out_valid/out_ready, Result, sticky ovf), busy
module matrix_op_scheduler #(
  parameter int DATA_WIDTH  = 64,
  parameter int MATRIX_SIZE = 2,
  parameter int ELEM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  ovf,
  output logic                  busy
);
  localparam int NE = MATRIX_SIZE * MATRIX_SIZE;
  localparam int KW = NE > 1 ? $clog2(NE) : 1;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q, result_d;
  logic                  sub_q;
  logic [KW-1:0]         k;
  logic [ELEM_WIDTH-1:0] ak, bk;
  logic [ELEM_WIDTH:0]   full;
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    ak       = '0;
    bk       = '0;
    result_d = Result;
    for (int e = 0; e < NE; e++)
      if (k == KW'(e)) begin
        ak = a_q[DATA_WIDTH-1-e*ELEM_WIDTH -: ELEM_WIDTH];
        bk = b_q[DATA_WIDTH-1-e*ELEM_WIDTH -: ELEM_WIDTH];
      end
    full = sub_q ? {1'b0, ak} - {1'b0, bk} : {1'b0, ak} + {1'b0, bk};
    for (int e = 0; e < NE; e++)
      if (k == KW'(e)) result_d[DATA_WIDTH-1-e*ELEM_WIDTH -: ELEM_WIDTH] = full[ELEM_WIDTH-1:0];
  end
  always_comb begin
    state_d = state == IDLE    ? (in_valid ? COMPUTE : IDLE) :
              state == COMPUTE ? (k == KW'(NE-1) ? DONE : COMPUTE) :
                                 (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      k      <= '0;
      Result <= '0;
      ovf    <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q    <= A;
      b_q    <= B;
      sub_q  <= op_sub;
      k      <= '0;
      Result <= '0;
      ovf    <= 1'b0;
    end else if (state == COMPUTE) begin
      Result <= result_d;
      ovf    <= ovf | full[ELEM_WIDTH];
      k      <= k + KW'(1);
    end
  end
endmodule

// File: tb/tb_matrix_op_scheduler.sv
// tb_matrix_op_scheduler: randomized self-checking bench against a per-element arithmetic model
module tb_matrix_op_scheduler;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op_sub, out_valid, out_ready, ovf, busy;
  logic [63:0] A, B, Result;
  int          checks = 0, errors = 0, cyc = 0, prev_acc = -1, prev_hold = 0;

  matrix_op_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [63:0] r = '0;
    logic        o = 1'b0;
    int unsigned ea, eb;
    for (int i = 0; i < 4; i++) begin
      ea = a[63-16*i -: 16];
      eb = b[63-16*i -: 16];
      if (s) begin
        r[63-16*i -: 16] = 16'((ea - eb) & 32'hFFFF);
        o = o | (ea < eb);
      end else begin
        r[63-16*i -: 16] = 16'((ea + eb) & 32'hFFFF);
        o = o | ((ea + eb) > 32'hFFFF);
      end
    end
    return {o, r};
  endfunction

  function automatic logic [63:0] rnd_mat;
    logic [63:0] m;
    m = {$urandom, $urandom};
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 3) == 0) m[16*i +: 16] = $urandom_range(0, 1) ? 16'hFFFF : 16'h0000;
    return m;
  endfunction

  task automatic do_txn(input logic [63:0] a, input logic [63:0] b, input logic s, input int hold, input bit keep);
    logic [64:0] exp;
    int          n, acc;
    exp       = model(a, b, s);
    A         = a;
    B         = b;
    op_sub    = s;
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    check("in_ready_idle", 64'(in_ready), 64'(1));
    tick;
    acc = cyc;
    if (prev_acc >= 0) check("accept_spacing", 64'(acc - prev_acc), 64'(6 + prev_hold));
    prev_acc = acc;
    check("in_ready_after_accept", 64'(in_ready), 64'(0));
    check("busy_after_accept", 64'(busy), 64'(1));
    check("result_cleared", Result, 64'(0));
    in_valid = keep;
    A        = rnd_mat();
    B        = rnd_mat();
    op_sub   = 1'($urandom_range(0, 1));
    n        = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
      if (!out_valid) out_ready = 1'($urandom_range(0, 1));
    end
    check("latency", 64'(n), 64'(4));
    check("result", Result, exp[63:0]);
    check("ovf", 64'(ovf), 64'(exp[64]));
    check("in_ready_done", 64'(in_ready), 64'(0));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      A         = rnd_mat();
      B         = rnd_mat();
      tick;
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_result", Result, exp[63:0]);
      check("hold_ovf", 64'(ovf), 64'(exp[64]));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid  = keep;
    out_ready = 1'b1;
    tick;
    check("valid_cleared", 64'(out_valid), 64'(0));
    check("back_idle_ready", 64'(in_ready), 64'(1));
    check("back_idle_busy", 64'(busy), 64'(0));
    check("result_retained", Result, exp[63:0]);
    check("ovf_retained", 64'(ovf), 64'(exp[64]));
    prev_hold = hold;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_sub    = 1'b0;
    A         = '0;
    B         = '0;
    tick;
    tick;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", Result, 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    tick;
    do_txn(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, 0, 1'b0);
    check("plan_add", Result, 64'h0011_0022_0033_0044);
    do_txn(64'hFFFF_0000_0000_0001, 64'h0001_0000_0000_0001, 1'b0, 0, 1'b0);
    check("plan_ovf_result", Result, 64'h0000_0000_0000_0002);
    check("plan_ovf_flag", 64'(ovf), 64'(1));
    do_txn(64'h0005_0010_0000_0100, 64'h0003_0001_0001_0100, 1'b1, 0, 1'b0);
    check("plan_sub_result", Result, 64'h0002_000F_FFFF_0000);
    check("plan_sub_flag", 64'(ovf), 64'(1));
    do_txn(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1, 10, 1'b0);
    A        = 64'h0F0F_0F0F_0F0F_0F0F;
    B        = 64'h0101_0101_0101_0101;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n    = 1'b1;
    prev_acc = -1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_result", Result, 64'(0));
    check("midrst_ovf", 64'(ovf), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_ready", 64'(in_ready), 64'(1));
    do_txn(64'h0F0F_0F0F_0F0F_0F0F, 64'h0101_0101_0101_0101, 1'b0, 0, 1'b0);
    check("after_rst_result", Result, 64'h1010_1010_1010_1010);
    do_txn(64'h0000_0001_0002_0003, 64'h0000_0001_0001_0001, 1'b1, 0, 1'b1);
    do_txn(64'h8000_8000_7FFF_0001, 64'h8000_0001_0001_FFFF, 1'b0, 0, 1'b1);
    check("b2b_second", Result, 64'h0000_8001_8000_0000);
    for (int t = 0; t < 40; t++)
      do_txn(rnd_mat(), rnd_mat(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
